// File: rtl/fetch_prefetch_stage.sv
// Instruction fetch stage: Wishbone classic master filling a prefetch FIFO,
// with bounded retry, sticky bus fault and jump-driven flush/abort.
module fetch_prefetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FETCH_DEPTH = 4,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ADR_O,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  output logic [2:0]  CTI_O,
  input  logic        ACK_I,
  input  logic        ERR_I,
  input  logic        RTY_I,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        stall_o,
  input  logic        jmp_i,
  input  logic [31:0] jmp_addr_i,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);

  localparam int AW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FETCH_DEPTH);
  localparam logic [RW-1:0] RETRY_MAX_C = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    BACKOFF = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] retry_cnt;
  logic          fault;
  logic [31:0]   fault_pc;
  logic [31:0]   pc_mem  [FETCH_DEPTH];
  logic [31:0]   ins_mem [FETCH_DEPTH];

  logic push;
  logic pop;
  logic rty_ok;
  logic take_fault;
  logic unused_jmp_bits;

  assign unused_jmp_bits = ^jmp_addr_i[1:0];

  // A jump masks every other event in its cycle, including any termination.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    rty_ok     = 1'b0;
    take_fault = 1'b0;
    if (!jmp_i) begin
      pop  = (count != {CW{1'b0}}) && ready_i;
      if (state == REQ) begin
        push       = ACK_I;
        rty_ok     = RTY_I && (retry_cnt < RETRY_MAX_C);
        take_fault = ERR_I || (RTY_I && (retry_cnt >= RETRY_MAX_C));
      end else begin
        push = 1'b0;
      end
    end else begin
      pop = 1'b0;
    end
    count_next = count + CW'(push) - CW'(pop);
  end

  // Next-state logic; issue is gated on post-pop occupancy so a pop from a
  // full FIFO lets a new request start on the following cycle.
  always_comb begin
    state_next = state;
    if (jmp_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if ((count_next < DEPTH_C) && !fault) state_next = REQ;
          else                                   state_next = IDLE;
        end
        REQ: begin
          if (push)            state_next = (count_next < DEPTH_C) ? REQ : IDLE;
          else if (rty_ok)     state_next = BACKOFF;
          else if (take_fault) state_next = FAULT;
          else                 state_next = REQ;
        end
        BACKOFF: state_next = REQ;
        FAULT:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Fetch address, FIFO pointers, retry counter and sticky fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      count     <= {CW{1'b0}};
      wr_ptr    <= {AW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      retry_cnt <= {RW{1'b0}};
      fault     <= 1'b0;
      fault_pc  <= 32'h0000_0000;
    end else if (jmp_i) begin
      fetch_pc  <= {jmp_addr_i[31:2], 2'b00};
      count     <= {CW{1'b0}};
      wr_ptr    <= {AW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      retry_cnt <= {RW{1'b0}};
      fault     <= 1'b0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        fetch_pc  <= fetch_pc + 32'd4;
        retry_cnt <= {RW{1'b0}};
      end else if (rty_ok) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (take_fault) begin
        fault    <= 1'b1;
        fault_pc <= fetch_pc;
      end
    end
  end

  // FIFO storage; contents are only observable through valid-gated outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= DAT_I;
    end
  end

  assign ADR_O      = fetch_pc;
  assign STB_O      = (state == REQ);
  assign CYC_O      = (state == REQ);
  assign DAT_O      = 32'h0000_0000;
  assign WE_O       = 1'b0;
  assign CTI_O      = 3'b000;
  assign valid_o    = (count != {CW{1'b0}});
  assign stall_o    = !valid_o;
  assign ins_o      = valid_o ? ins_mem[rd_ptr] : 32'h0000_0000;
  assign pc_o       = valid_o ? pc_mem[rd_ptr] : 32'h0000_0000;
  assign fault_o    = fault;
  assign fault_pc_o = fault_pc;

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Bench for fetch_prefetch_stage: directed sequences, a jump/retry vector
// table and randomized traffic against a queue-based reference model.
module tb_fetch_prefetch_stage;

  localparam int DEPTH = 4;
  localparam int MAXR  = 3;

  logic        clk;
  logic        rst;
  logic [31:0] ADR_O;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [2:0]  CTI_O;
  logic        ACK_I;
  logic        ERR_I;
  logic        RTY_I;
  logic [31:0] ins_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        stall_o;
  logic        jmp_i;
  logic [31:0] jmp_addr_i;
  logic        fault_o;
  logic [31:0] fault_pc_o;

  fetch_prefetch_stage #(
    .RESET_PC(32'h0000_0000), .FETCH_DEPTH(DEPTH), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .ADR_O(ADR_O), .DAT_I(DAT_I), .DAT_O(DAT_O),
    .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .CTI_O(CTI_O),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .ins_o(ins_o), .pc_o(pc_o),
    .valid_o(valid_o), .ready_i(ready_i), .stall_o(stall_o), .jmp_i(jmp_i),
    .jmp_addr_i(jmp_addr_i), .fault_o(fault_o), .fault_pc_o(fault_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {pc, ins}, next fetch address, fault, retries.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fpc;
  int          m_retry;
  logic        m_stb;

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0; m_fault = 1'b0; m_fpc = 32'h0; m_retry = 0; m_stb = 1'b0;
  endtask

  task automatic model_step(input logic rdy, input logic jmp, input logic [31:0] ja,
                            input logic ack, input logic rty, input logic err,
                            input logic [31:0] dat);
    logic rty_taken;
    rty_taken = 1'b0;
    if (jmp) begin
      m_q.delete();
      m_pc = {ja[31:2], 2'b00}; m_fault = 1'b0; m_retry = 0; m_stb = 1'b0;
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (m_stb && ack) begin
        m_q.push_back({m_pc, dat});
        m_pc = m_pc + 32'd4;
        m_retry = 0;
      end else if (m_stb && rty && m_retry < MAXR) begin
        m_retry++;
        rty_taken = 1'b1;
      end else if (m_stb && (rty || err)) begin
        m_fault = 1'b1;
        m_fpc = m_pc;
      end
      m_stb = !m_fault && !rty_taken && (m_q.size() < DEPTH);
    end
  endtask

  function automatic logic [168:0] model_vec();
    logic v;
    logic [63:0] head;
    v = (m_q.size() != 0);
    head = v ? m_q[0] : 64'h0;
    return {m_stb, m_stb, m_pc, v, head[31:0], head[63:32], !v, m_fault, m_fpc,
            32'h0, 1'b0, 3'b000};
  endfunction

  function automatic logic [168:0] dut_vec();
    return {STB_O, CYC_O, ADR_O, valid_o, ins_o, pc_o, stall_o, fault_o, fault_pc_o,
            DAT_O, WE_O, CTI_O};
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: resp 0=none 1=ACK 2=RTY 3=ERR (only while the DUT strobes).
  task automatic cycle(input logic rdy, input logic jmp, input logic [31:0] ja, input int resp);
    ready_i    = rdy;
    jmp_i      = jmp;
    jmp_addr_i = ja;
    ACK_I      = STB_O && (resp == 1);
    RTY_I      = STB_O && (resp == 2);
    ERR_I      = STB_O && (resp == 3);
    DAT_I      = {2'b00, ADR_O[31:2]};
    model_step(rdy, jmp, ja, ACK_I, RTY_I, ERR_I, DAT_I);
    @(posedge clk);
    #1;
    chk("model", dut_vec(), model_vec());
    jmp_i = 1'b0; ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ja;
    int          n_rty;
    bit          use_err;
    logic [31:0] exp_adr;
    int          exp_backoff;
    bit          exp_fault;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fetches, pops, backoff, stb_seen, r;
    tbl[0] = '{32'h0000_0013, 3, 1'b0, 32'h0000_0010, 3, 1'b0, 32'h0000_0014};
    tbl[1] = '{32'h0000_0010, 4, 1'b0, 32'h0000_0010, 3, 1'b1, 32'h0000_0010};
    tbl[2] = '{32'h0000_0103, 0, 1'b0, 32'h0000_0100, 0, 1'b0, 32'h0000_0104};
    tbl[3] = '{32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFFC, 0, 1'b0, 32'h0000_0000};
    tbl[4] = '{32'h0000_0008, 0, 1'b1, 32'h0000_0008, 0, 1'b1, 32'h0000_0008};
    tbl[5] = '{32'h2000_0001, 2, 1'b0, 32'h2000_0000, 2, 1'b0, 32'h2000_0004};

    rst = 1'b0; ready_i = 1'b0; jmp_i = 1'b0; jmp_addr_i = 32'h0;
    ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b0; DAT_I = 32'h0;
    model_reset();
    #3;
    chk("reset", dut_vec(), {2'b00, 32'h0, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000});
    #9 rst = 1'b1;

    // Fill with consumer stalled: exactly four fetches, then bus idle.
    fetches = 0;
    for (int k = 0; k < 8; k++) begin
      if (STB_O) begin
        chk("fetch_adr", ADR_O, 32'(fetches * 4));
        fetches++;
      end
      cycle(1'b0, 1'b0, 32'h0, 1);
    end
    chk("fetch_count", fetches, 4);
    chk("full_head", {STB_O, valid_o, ins_o, pc_o}, {1'b0, 1'b1, 64'h0});

    // Streaming: one pop per cycle in address order.
    pops = 0;
    for (int k = 0; k < 20; k++) begin
      if (valid_o) begin
        chk("pop_seq", {ins_o, pc_o}, {32'(pops), 32'(pops * 4)});
        pops++;
      end
      cycle(1'b1, 1'b0, 32'h0, 1);
    end
    chk("stream_pops", pops, 20);

    // Reset in the middle of a bus cycle.
    rst = 1'b0;
    #2;
    model_reset();
    chk("async_reset", dut_vec(), model_vec());
    #2 rst = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 0);
    chk("stb_first_edge", {STB_O, ADR_O}, {1'b1, 32'h0});

    // ERR with two entries queued: fault latched, queue still drains.
    cycle(1'b0, 1'b1, 32'h0, 0);
    cycle(1'b0, 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b0, 32'h0, 1);
    cycle(1'b0, 1'b0, 32'h0, 1);
    cycle(1'b0, 1'b0, 32'h0, 3);
    chk("err_fault", {STB_O, fault_o, fault_pc_o}, {1'b0, 1'b1, 32'h8});
    pops = 0; stb_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid_o) begin
        chk("fault_pop", {ins_o, pc_o}, {32'(pops), 32'(pops * 4)});
        pops++;
      end
      cycle(1'b1, 1'b0, 32'h0, 1);
      stb_seen += int'(STB_O);
    end
    chk("fault_pops", pops, 2);
    chk("fault_no_stb", stb_seen, 0);

    // Jump in the same cycle as an ACK discards the data.
    cycle(1'b0, 1'b1, 32'h40, 0);
    cycle(1'b0, 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b0, 32'h0, 1);
    cycle(1'b0, 1'b1, 32'h103, 1);
    chk("jmp_ack_flush", {valid_o, STB_O, fault_o}, 3'b000);
    cycle(1'b0, 1'b0, 32'h0, 0);
    chk("jmp_ack_target", {STB_O, ADR_O, valid_o}, {1'b1, 32'h100, 1'b0});

    // Table: jump target, retry/error response, resulting fault and address.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, tbl[i].ja, 0);
      chk("tbl_jmp_clear", {STB_O, valid_o, fault_o}, 3'b000);
      cycle(1'b0, 1'b0, 32'h0, 0);
      chk("tbl_jmp_target", {STB_O, ADR_O}, {1'b1, tbl[i].exp_adr});
      backoff = 0;
      for (int j = 0; j < tbl[i].n_rty; j++) begin
        cycle(1'b0, 1'b0, 32'h0, 2);
        if (!fault_o) begin
          if (!STB_O) backoff++;
          cycle(1'b0, 1'b0, 32'h0, 0);
        end
      end
      if (tbl[i].use_err) cycle(1'b0, 1'b0, 32'h0, 3);
      else if (!fault_o)  cycle(1'b0, 1'b0, 32'h0, 1);
      chk("tbl_backoffs", backoff, tbl[i].exp_backoff);
      chk("tbl_fault", {fault_o, fault_o ? fault_pc_o : pc_o}, {tbl[i].exp_fault, tbl[i].exp_adr});
      chk("tbl_next_adr", ADR_O, tbl[i].exp_next);
    end

    // Randomized traffic against the model, with one mid-run async reset.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ja;
      r  = $urandom_range(0, 99);
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (i == 1500) begin
        #3 rst = 1'b0;
        #1;
        model_reset();
        chk("rand_reset", dut_vec(), model_vec());
        #1 rst = 1'b1;
      end
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3), ja,
            (r < 60) ? 1 : (r < 75) ? 0 : (r < 92) ? 2 : 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_stage.md
# fetch_prefetch_stage

Parametrised instruction fetch stage with a prefetch queue. Acts as a Wishbone B4 classic-cycle master toward instruction memory, fetching sequential 32-bit words into a FIFO of FETCH_DEPTH entries. The decode stage drains the FIFO through a valid/ready handshake. The block adds three behaviours: bounded retry on RTY_I, a sticky fault on ERR_I, and jump-driven flush with bus-cycle abort.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FETCH_DEPTH, 4: FIFO entries; power of two, ≥ 2.
- MAX_RETRY, 3: consecutive RTY_I responses tolerated per address; the next RTY_I is treated as ERR_I.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ADR_O  out  32  word address; bits [1:0] always 0.
- DAT_I  in  32  read data.
- DAT_O  out  32  constant 0.
- WE_O  out  1  constant 0.
- STB_O, CYC_O  out  1  strobe and cycle; always driven equal.
- CTI_O  out  3  constant 3'b000 (classic).
- ACK_I, ERR_I, RTY_I  in  1  slave terminations; at most one is asserted per cycle.
- ins_o  out  32  FIFO head instruction; 0 when valid_o=0.
- pc_o  out  32  FIFO head address; 0 when valid_o=0.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts the head entry when valid_o && ready_i.
- stall_o  out  1  equals !valid_o.
- jmp_i  in  1  redirect request, single-cycle.
- jmp_addr_i  in  32  redirect target; bits [1:0] ignored and treated as 0.
- fault_o  out  1  sticky bus fault.
- fault_pc_o  out  32  address of the faulting fetch.

## Operation
- FSM states:
  - IDLE: bus idle; moves to REQ when count < FETCH_DEPTH and fault_o=0.
  - REQ: STB_O=CYC_O=1, ADR_O=fetch_pc.
  - BACKOFF: one idle cycle after RTY_I, then back to REQ.
  - FAULT: bus idle; waits for jmp_i.
- ACK_I in REQ:
  - push {fetch_pc, DAT_I}; fetch_pc += 4 (32-bit wrap from FFFF_FFFC to 0); retry counter cleared.
  - If count after the push is < FETCH_DEPTH, stay in REQ with the new ADR_O; otherwise go to IDLE.
- RTY_I in REQ with retry counter < MAX_RETRY: increment the counter, go to BACKOFF, same address.
- RTY_I with counter = MAX_RETRY, or ERR_I in REQ: set fault_o=1 and fault_pc_o=fetch_pc, go to FAULT. Entries already queued remain poppable.
- Pop: when valid_o && ready_i, the head advances. Simultaneous push and pop keeps count unchanged. A push into a full FIFO cannot occur, because issue is gated on count < FETCH_DEPTH.
- jmp_i (priority over all other events in the same cycle):
  - FIFO flushed (count=0); fetch_pc={jmp_addr_i[31:2],2'b00}.
  - fault_o cleared, retry counter cleared; state goes to IDLE.
  - The bus cycle in progress is aborted: STB_O and CYC_O are low the next cycle.
  - A same-cycle ACK/ERR/RTY is discarded; a same-cycle pop has no effect.
- Reset values: STB_O=CYC_O=WE_O=0, DAT_O=0, CTI_O=0, ADR_O=RESET_PC, valid_o=0, stall_o=1, ins_o=pc_o=0, fault_o=0, fault_pc_o=0, fetch_pc=RESET_PC, state IDLE.
- Reset asserted mid-cycle: outputs return to reset values immediately and the in-flight transfer is dropped.

## Timing
- After reset release with an empty FIFO: STB_O rises on the 1st rising edge.
- ACK_I sampled at edge N: the entry is visible (valid_o=1) after edge N; ADR_O advances after edge N.
- With a zero-wait slave, sustained throughput is one word per cycle while the FIFO is not full.
- RTY_I at edge N: STB_O is low for cycle N+1 and high again from N+2.
- jmp_i at edge N: valid_o=0 and STB_O=0 after N; the first request to the target has STB_O=1 after N+1.
- Pop and refill: a pop at edge N from a full FIFO allows a new STB_O after N.

## Test plan
- Reset, RESET_PC=0, zero-wait RAM holding word i = i, ready_i=0 -> exactly 4 fetches (ADR 0,4,8,C), then STB_O=0; valid_o=1, ins_o=0, pc_o=0.
- ready_i=1 continuously -> ins_o/pc_o sequence (0,0),(1,4),(2,8)… one per cycle; no gaps once streaming.
- Slave answers RTY_I 3 times then ACK at 0x10 -> 3 BACKOFF cycles, entry (0x10) pushed, fault_o=0; with 4 RTY_I -> fault_o=1, fault_pc_o=0x10.
- ERR_I at 0x8 with 2 entries queued -> fault_o=1, fault_pc_o=8, both entries still popped; no further STB_O until jmp_i.
- jmp_i with jmp_addr_i=0x103 in the same cycle as ACK_I -> ACK data discarded, FIFO empty, next ADR_O=0x100, fault cleared.
- PC wrap: jmp to 0xFFFF_FFFC -> fetches FFFF_FFFC, then 0x0000_0000.
